// File: rtl/apix_pkg.sv
// Shared constants and state encoding for the APIX transmitter and receiver.
package apix_pkg;

    localparam logic [7:0] APIX_SYNC     = 8'hA5;
    localparam logic [7:0] APIX_CRC_POLY = 8'h07;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA,
        CRC
    } apix_tx_state_t;

endpackage

// File: rtl/apix_crc8_step.sv
// One LANES-bit parallel CRC-8 step (no reflection, no final XOR).
// bits[LANES-1] is lane 0 and is folded in first.
module apix_crc8_step
    import apix_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic [7:0]       crc_in,
    input  logic [LANES-1:0] bits,
    output logic [7:0]       crc_out
);

    always_comb begin : step
        logic [7:0] c;
        c = crc_in;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (c[7] ^ bits[i]) begin
                c = {c[6:0], 1'b0} ^ APIX_CRC_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/apix_tx_lanes.sv
// Multi-lane APIX transmitter: frames pixels into SYNC / DATA / CRC-8 packets
// and shifts them out MSB-first across LANES lanes.
module apix_tx_lanes
    import apix_pkg::*;
#(
    parameter int PIXEL_W    = 24,
    parameter int LANES      = 1,
    parameter int PKT_PIXELS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIXEL_W-1:0] pixel_data,
    input  logic               pixel_valid,
    output logic               pixel_ready,
    output logic [LANES-1:0]   apix_data,
    output logic               apix_clk,
    output logic               apix_frame,
    output logic               underrun,
    output logic               pkt_done
);

    localparam int CPP     = PIXEL_W / LANES;
    localparam int SC      = 8 / LANES;
    localparam int SH_W    = (PIXEL_W > 8) ? PIXEL_W : 8;
    localparam int CNT_MAX = (CPP > SC) ? CPP : SC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int PIX_W   = (PKT_PIXELS > 1) ? $clog2(PKT_PIXELS) : 1;

    localparam logic [CNT_W-1:0] CPP_LAST = CNT_W'(CPP - 1);
    localparam logic [CNT_W-1:0] SC_LAST  = CNT_W'(SC - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PKT_PIXELS - 1);

    apix_tx_state_t   state_q, state_d;
    logic [SH_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic [7:0]       crc_q, crc_d;
    logic             underrun_q, underrun_d;

    logic [7:0]         crc_step;
    logic [PIXEL_W-1:0] pix_word;
    logic [SH_W-1:0]    pix_load, sync_load, crc_load;

    apix_crc8_step #(.LANES(LANES)) u_crc_step (
        .crc_in  (crc_q),
        .bits    (shift_q[SH_W-1 -: LANES]),
        .crc_out (crc_step)
    );

    // A missing pixel at a ready cycle is replaced by an all-zero fill pixel.
    assign pix_word  = pixel_valid ? pixel_data : '0;
    assign pix_load  = SH_W'(pix_word) << (SH_W - PIXEL_W);
    assign sync_load = SH_W'(APIX_SYNC) << (SH_W - 8);
    assign crc_load  = SH_W'(crc_step) << (SH_W - 8);

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q << LANES;
        cnt_d      = cnt_q + CNT_W'(1);
        pix_d      = pix_q;
        crc_d      = crc_q;
        underrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                shift_d = '0;
                if (pixel_valid) begin
                    state_d = SYNC;
                    shift_d = sync_load;
                end
            end
            SYNC: begin
                crc_d = '0;
                pix_d = '0;
                if (cnt_q == SC_LAST) begin
                    state_d    = DATA;
                    cnt_d      = '0;
                    shift_d    = pix_load;
                    underrun_d = !pixel_valid;
                end
            end
            DATA: begin
                crc_d = crc_step;
                if (cnt_q == CPP_LAST) begin
                    cnt_d = '0;
                    if (pix_q == PIX_LAST) begin
                        state_d = CRC;
                        shift_d = crc_load;
                    end else begin
                        pix_d      = pix_q + PIX_W'(1);
                        shift_d    = pix_load;
                        underrun_d = !pixel_valid;
                    end
                end
            end
            CRC: begin
                if (cnt_q == SC_LAST) begin
                    cnt_d = '0;
                    if (pixel_valid) begin
                        state_d = SYNC;
                        shift_d = sync_load;
                    end else begin
                        state_d = IDLE;
                        shift_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            pix_q      <= '0;
            crc_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            pix_q      <= pix_d;
            crc_q      <= crc_d;
            underrun_q <= underrun_d;
        end
    end

    // Ready depends only on state and counters, never on pixel_valid.
    assign pixel_ready = ((state_q == SYNC) && (cnt_q == SC_LAST)) ||
                         ((state_q == DATA) && (cnt_q == CPP_LAST) && (pix_q != PIX_LAST));
    assign apix_data   = shift_q[SH_W-1 -: LANES];
    assign apix_clk    = clk;
    assign apix_frame  = (state_q != IDLE);
    assign underrun    = underrun_q;
    assign pkt_done    = (state_q == CRC) && (cnt_q == SC_LAST);

endmodule
